edf_pkt_reader: RTL and testbench



---
 rtl/edf_pkt_reader.sv | 108 ++++++++++
 tb/tb_edf_pkt_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/edf_pkt_reader.sv
// edf_pkt_reader: pops words from the ingress FIFO and parses each header into an absolute deadline.
// Payload words are framed with sop/eop and delivered through a small output buffer with valid/ready.
module edf_pkt_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int TIME_WIDTH = 16,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic [TIME_WIDTH-1:0] time_now,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [TIME_WIDTH-1:0] pkt_deadline,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + 2 + TIME_WIDTH;

    typedef enum logic {HDR, PAY} state_t;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [7:0]            remain_q, remain_d;
    logic                  sop_pend_q, sop_pend_d;
    logic [TIME_WIDTH-1:0] dl_q, dl_d;
    logic [EW-1:0]         mem_q [OBUF_DEPTH];
    logic [EW-1:0]         mem_d [OBUF_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                  push, pop;

    // The in-flight read is counted so the returning word always finds a free slot.
    assign fifo_rd_en = !rst && !fifo_empty && !rd_en_q
                        && (cnt_q + CW'(rd_en_q) < CW'(OBUF_DEPTH));
    assign pkt_valid  = cnt_q != '0;
    assign {pkt_data, pkt_sop, pkt_eop, pkt_deadline} = pkt_valid ? mem_q[rp_q] : '0;
    assign pkt_cnt    = pkt_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        sop_pend_d = sop_pend_q;
        dl_d       = dl_q;
        mem_d      = mem_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        rd_en_d    = fifo_rd_en;
        if (rd_en_q && state_q == HDR) begin
            if (fifo_rd_data[7:0] == 8'd0) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                remain_d   = fifo_rd_data[7:0];
                dl_d       = time_now + TIME_WIDTH'(fifo_rd_data[15:8]);
                sop_pend_d = 1'b1;
                state_d    = PAY;
            end
        end else if (rd_en_q) begin
            push          = 1'b1;
            mem_d[wp_q]   = {fifo_rd_data, sop_pend_q, remain_q == 8'd1, dl_q};
            sop_pend_d    = 1'b0;
            remain_d      = remain_q - 8'd1;
            state_d       = remain_q == 8'd1 ? HDR : PAY;
        end
        pop       = pkt_valid && pkt_ready;
        wp_d      = push ? wp_q + PW'(1) : wp_q;
        rp_d      = pop ? rp_q + PW'(1) : rp_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        pkt_cnt_d = (pop && pkt_eop) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HDR;
            rd_en_q    <= 1'b0;
            remain_q   <= '0;
            sop_pend_q <= 1'b0;
            dl_q       <= '0;
            mem_q      <= '{default: '0};
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            remain_q   <= remain_d;
            sop_pend_q <= sop_pend_d;
            dl_q       <= dl_d;
            mem_q      <= mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_edf_pkt_reader.sv
// tb_edf_pkt_reader: directed checks of edf_pkt_reader against a lagging-empty FIFO model.
module tb_edf_pkt_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_rd_data = '0;
    logic        fifo_rd_en;
    logic [15:0] time_now = '0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [15:0] pkt_data;
    logic        pkt_sop, pkt_eop;
    logic [15:0] pkt_deadline;
    logic [15:0] pkt_cnt, drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fv = -1;
    logic [15:0] fq[$];
    logic [33:0] out_q[$];
    int rd_cyc[$];
    logic [15:0] hold;

    edf_pkt_reader dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .time_now(time_now), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_deadline(pkt_deadline), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: the empty flag reflects occupancy as of the previous edge.
    always @(posedge clk) begin
        fifo_empty <= (fq.size() == 0);
        if (fifo_rd_en) fifo_rd_data <= fq.pop_front();
    end

    always @(posedge clk) begin
        if (fifo_rd_en) rd_cyc.push_back(cyc);
        if (pkt_valid && fv < 0) fv = cyc;
        if (pkt_valid && pkt_ready) out_q.push_back({pkt_data, pkt_sop, pkt_eop, pkt_deadline});
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int n, input string tag);
        for (int i = 0; i < 300 && out_q.size() < n; i++) @(negedge clk);
        chk(tag, out_q.size() >= n, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_out", {pkt_data, pkt_sop, pkt_eop, pkt_deadline}, 0);
        chk("rst_cnts", {pkt_cnt, drop_cnt}, 0);
        rst = 1'b0;
        idle(2);

        pkt_ready = 1'b1;
        time_now = 16'h0100;
        fq = '{16'h0503, 16'hAAA1, 16'hBBB2, 16'hCCC3};
        wait_out(3, "t1_timeout");
        chk("t1_w0", out_q[0], {16'hAAA1, 1'b1, 1'b0, 16'h0105});
        chk("t1_w1", out_q[1], {16'hBBB2, 1'b0, 1'b0, 16'h0105});
        chk("t1_w2", out_q[2], {16'hCCC3, 1'b0, 1'b1, 16'h0105});
        chk("t1_latency", fv, rd_cyc[1] + 2);
        idle(3);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_idle_valid", pkt_valid, 0);

        out_q.delete();
        time_now = 16'h0200;
        fq = '{16'h0700, 16'h0101, 16'hD00D};
        wait_out(1, "t2_timeout");
        idle(4);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_count", out_q.size(), 1);
        chk("t2_w0", out_q[0], {16'hD00D, 1'b1, 1'b1, 16'h0201});
        chk("t2_pkt_cnt", pkt_cnt, 2);

        out_q.delete();
        rd_cyc.delete();
        pkt_ready = 1'b0;
        time_now = 16'h0300;
        fq.push_back(16'h000A);
        for (int i = 0; i < 10; i++) fq.push_back(16'h1000 + 16'(i));
        idle(60);
        chk("t3_reads", rd_cyc.size(), 5);
        chk("t3_rd_en_low", fifo_rd_en, 0);
        chk("t3_head", {pkt_valid, pkt_data, pkt_sop, pkt_eop}, {1'b1, 16'h1000, 1'b1, 1'b0});
        hold = pkt_data;
        idle(3);
        chk("t3_stable", pkt_data, hold);
        pkt_ready = 1'b1;
        wait_out(10, "t3_timeout");
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_w%0d", i), out_q[i],
                {16'h1000 + 16'(i), i == 0, i == 9, 16'h0300});
        idle(4);
        chk("t3_count", out_q.size(), 10);
        chk("t3_pkt_cnt", pkt_cnt, 3);

        out_q.delete();
        time_now = 16'hFFF0;
        fq = '{16'h2002, 16'hE001, 16'hE002};
        wait_out(2, "t4_timeout");
        chk("t4_w0", out_q[0], {16'hE001, 1'b1, 1'b0, 16'h0010});
        chk("t4_w1", out_q[1], {16'hE002, 1'b0, 1'b1, 16'h0010});
        idle(3);
        chk("t4_pkt_cnt", pkt_cnt, 4);

        rd_cyc.delete();
        fq = '{16'h0000};
        for (int i = 0; i < 20 && !fifo_rd_en; i++) @(negedge clk);
        chk("t5_pulse", fifo_rd_en, 1);
        @(negedge clk);
        chk("t5_lag_empty", fifo_empty, 0);
        chk("t5_no_rd", fifo_rd_en, 0);
        idle(8);
        chk("t5_reads", rd_cyc.size(), 1);
        chk("t5_drop_cnt", drop_cnt, 2);

        out_q.delete();
        time_now = 16'h0350;
        fq = '{16'h0005, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005};
        for (int i = 0; i < 100 && out_q.size() < 2; i++) @(negedge clk);
        chk("t6_two_out", out_q.size(), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_out", {fifo_rd_en, pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_deadline}, 0);
        chk("t6_rst_cnts", {pkt_cnt, drop_cnt}, 0);
        fq.delete();
        idle(2);
        out_q.delete();
        rst = 1'b0;
        time_now = 16'h0400;
        fq = '{16'h0301, 16'h7777};
        wait_out(1, "t6_timeout");
        idle(4);
        chk("t6_w0", out_q[0], {16'h7777, 1'b1, 1'b1, 16'h0403});
        chk("t6_cnts", {pkt_cnt, drop_cnt}, {16'd1, 16'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
